// File: rtl/uart_brg_sched.sv
// Eight-line UART baud-rate generator built around one shared 32-bit fractional-N adder.
// A rotating service pointer gives each line one accumulate slot every eight clocks.
module uart_brg_sched #(
    parameter int unsigned CLKFRQ = 20000000,
    parameter int unsigned CLKDIV = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic [7:0]  lineEN,
    input  logic [31:0] speed,
    output logic [7:0]  brgCLKEN
);

    // Phase increment for a baud rate given in tenths of a baud (134.5 baud is fractional).
    function automatic logic [63:0] calc_incr(input longint unsigned baud_x10);
        logic [95:0] num;
        logic [95:0] den;
        logic [95:0] quo;
        num = (96'd1 << 32) * 96'(CLKDIV) * 96'd8 * 96'(baud_x10);
        den = 96'(CLKFRQ) * 96'd10;
        quo = (num + (den >> 1)) / den;
        return 64'(quo);
    endfunction

    function automatic logic [31:0] incr32(input longint unsigned baud_x10);
        return 32'(calc_incr(baud_x10));
    endfunction

    localparam logic [63:0] INCR_MAX = calc_incr(64'd1152000);

    localparam logic [31:0] INCR_TAB [16] = '{
        incr32(64'd500),   incr32(64'd750),   incr32(64'd1100),  incr32(64'd1345),
        incr32(64'd1500),  incr32(64'd3000),  incr32(64'd6000),  incr32(64'd12000),
        incr32(64'd18000), incr32(64'd20000), incr32(64'd24000), incr32(64'd36000),
        incr32(64'd48000), incr32(64'd72000), incr32(64'd96000), incr32(64'd1152000)
    };

    if (INCR_MAX >= 64'h1_0000_0000) begin : g_incr_range
        $error("uart_brg_sched: 115200 baud increment does not fit in 32 bits for this CLKFRQ/CLKDIV");
    end

    logic [2:0]  ptr;
    logic [31:0] acc [8];
    logic [3:0]  snap [8];
    logic [7:0]  valid;

    logic [3:0]  sel_speed;
    logic [31:0] cur_acc;
    logic [3:0]  cur_snap;
    logic [31:0] incr;
    logic [31:0] base;
    logic [32:0] sum;
    logic [31:0] nxt_acc;
    logic [3:0]  nxt_snap;
    logic        nxt_valid;
    logic        fire;

    assign sel_speed = speed[{ptr, 2'b00} +: 4];

    // brgCLKEN is a one-cycle strobe with no back-pressure: bit n rises for a single
    // clock, one cycle after the slot of line n whose addition carried out of bit 31.
    always_comb begin
        cur_acc   = acc[ptr];
        cur_snap  = snap[ptr];
        incr      = INCR_TAB[sel_speed];
        base      = valid[ptr] ? cur_acc : 32'd0;
        sum       = {1'b0, base} + {1'b0, incr};
        nxt_acc   = 32'd0;
        nxt_snap  = cur_snap;
        nxt_valid = valid[ptr];
        fire      = 1'b0;
        if (!lineEN[ptr]) begin
            nxt_acc = 32'd0;
        end else if (sel_speed != cur_snap) begin
            // A new speed restarts the phase from zero and burns this slot.
            nxt_snap  = sel_speed;
            nxt_valid = 1'b1;
        end else if (!clr) begin
            nxt_acc   = sum[31:0];
            nxt_valid = 1'b1;
            fire      = sum[32];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= 3'd0;
            brgCLKEN <= 8'h00;
            valid    <= 8'h00;
            for (int i = 0; i < 8; i++) begin
                acc[i]  <= 32'd0;
                snap[i] <= 4'd0;
            end
        end else begin
            ptr       <= ptr + 3'd1;
            brgCLKEN  <= fire ? (8'd1 << ptr) : 8'h00;
            acc[ptr]  <= nxt_acc;
            snap[ptr] <= nxt_snap;
            if (clr) begin
                valid <= 8'h00;
            end else begin
                valid[ptr] <= nxt_valid;
            end
        end
    end

endmodule

// File: tb/tb_uart_brg_sched.sv
// Randomized scoreboard bench for uart_brg_sched: a phase-accumulator reference model
// predicts brgCLKEN every cycle; a monitor pops and compares, plus rate and latency checks.
module tb_uart_brg_sched;

    localparam int CLKFRQ = 20000000;
    localparam int CLKDIV = 16;
    localparam longint TWO32 = 64'h1_0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic [7:0]  lineEN = 8'h00;
    logic [31:0] speed = 32'h0;
    logic [7:0]  brgCLKEN;

    uart_brg_sched #(.CLKFRQ(CLKFRQ), .CLKDIV(CLKDIV)) dut (
        .clk(clk), .rst(rst), .clr(clr), .lineEN(lineEN), .speed(speed), .brgCLKEN(brgCLKEN)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    bit mon_en = 1'b0;
    int cyc = 0;
    int pulse_cnt[8];
    int first_pulse[8];

    real    baud_tab[16];
    longint incr_tab[16];
    longint m_acc[8];
    logic [3:0] m_snap[8];
    bit     m_valid[8];
    int     m_ptr;

    logic [7:0]  cur_en;
    logic [31:0] cur_spd;
    logic [7:0]  mon_exp;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic chk_rate(input string name, input int act, input real exp_v);
        real d;
        checks++;
        d = act - exp_v;
        if (d > 1.0 || d < -1.0) begin
            failures++;
            $display("FAIL %s: got %0d expected %0.2f +/-1", name, act, exp_v);
        end
    endtask

    function automatic real exp_pulses(input int n_clk, input int code);
        return 1.0 * n_clk * CLKDIV * baud_tab[code] / CLKFRQ;
    endfunction

    task automatic model_reset();
        m_ptr = 0;
        for (int i = 0; i < 8; i++) begin
            m_acc[i] = 0;
            m_snap[i] = 4'd0;
            m_valid[i] = 1'b0;
        end
    endtask

    // Applies the line rules to the slot that the next rising edge services.
    task automatic model_step(input logic [7:0] en, input logic [31:0] spd, input logic c,
                              output logic [7:0] e);
        int n;
        logic [3:0] s;
        longint phase;
        n = m_ptr;
        s = spd[n*4 +: 4];
        e = 8'h00;
        if (!en[n]) begin
            m_acc[n] = 0;
        end else if (s != m_snap[n]) begin
            m_acc[n] = 0;
            m_snap[n] = s;
            m_valid[n] = 1'b1;
        end else if (c) begin
            m_acc[n] = 0;
        end else begin
            phase = (m_valid[n] ? m_acc[n] : 64'd0) + incr_tab[s];
            if (phase >= TWO32) begin
                e[n] = 1'b1;
                phase = phase - TWO32;
            end
            m_acc[n] = phase;
            m_valid[n] = 1'b1;
        end
        if (c) for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
        m_ptr = (m_ptr + 1) % 8;
    endtask

    task automatic drive_cycle(input logic [7:0] en, input logic [31:0] spd, input logic c,
                               output logic [7:0] e);
        @(negedge clk);
        lineEN = en;
        speed = spd;
        clr = c;
        model_step(en, spd, c, e);
        exp_q.push_back(e);
    endtask

    task automatic hold(input int n);
        logic [7:0] e;
        for (int i = 0; i < n; i++) drive_cycle(cur_en, cur_spd, 1'b0, e);
    endtask

    task automatic release_reset(input logic [7:0] en, input logic [31:0] spd);
        logic [7:0] e;
        @(negedge clk);
        rst = 1'b0;
        lineEN = en;
        speed = spd;
        clr = 1'b0;
        model_step(en, spd, 1'b0, e);
        exp_q.push_back(e);
        mon_en = 1'b1;
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 8; i++) pulse_cnt[i] = 0;
    endtask

    // Monitor: compares every output cycle against the scoreboard queue.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (mon_en) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 64'd1, 64'd0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("brgCLKEN", {56'd0, brgCLKEN}, {56'd0, mon_exp});
                end
                chk("onehot", {63'd0, $countones(brgCLKEN) <= 1}, 64'd1);
                for (int n = 0; n < 8; n++) begin
                    if (brgCLKEN[n]) begin
                        pulse_cnt[n]++;
                        if (first_pulse[n] < 0) first_pulse[n] = cyc;
                    end
                end
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not complete in time");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int mark;
        int k;
        int others;
        logic [7:0] e;
        bit found;

        baud_tab = '{50.0, 75.0, 110.0, 134.5, 150.0, 300.0, 600.0, 1200.0, 1800.0,
                     2000.0, 2400.0, 3600.0, 4800.0, 7200.0, 9600.0, 115200.0};
        for (int s = 0; s < 16; s++)
            incr_tab[s] = longint'($floor(4294967296.0 * CLKDIV * 8 * baud_tab[s] / CLKFRQ + 0.5));
        for (int i = 0; i < 8; i++) begin
            pulse_cnt[i] = 0;
            first_pulse[i] = 0;
        end
        model_reset();

        // Reset holds the output low even with busy inputs.
        rst = 1'b1;
        lineEN = 8'hFF;
        speed = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_brg", {56'd0, brgCLKEN}, 64'd0);
        speed = $urandom;
        clr = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_brg_hold", {56'd0, brgCLKEN}, 64'd0);

        // Single line at 9600 baud.
        cur_spd = $urandom;
        cur_spd[3:0] = 4'd14;
        cur_en = 8'h01;
        release_reset(cur_en, cur_spd);
        clear_counts();
        hold(20000);
        chk_rate("rate_9600_l0", pulse_cnt[0], exp_pulses(20000, 14));
        others = 0;
        for (int n = 1; n < 8; n++) others += pulse_cnt[n];
        chk("idle_lines_quiet", 64'(others), 64'd0);

        // All lines at 115200 baud.
        cur_en = 8'hFF;
        cur_spd = 32'hFFFF_FFFF;
        hold(16);
        clear_counts();
        hold(10000);
        for (int n = 0; n < 8; n++)
            chk_rate($sformatf("rate_115200_l%0d", n), pulse_cnt[n], exp_pulses(10000, 15));

        // Line 3 disabled for 100 clocks, then restored.
        cur_spd = $urandom;
        cur_spd[15:12] = 4'd14;
        cur_spd[11:8] = 4'd15;
        hold(200);
        cur_en = 8'hF7;
        hold(1);
        clear_counts();
        hold(99);
        cur_en = 8'hFF;
        hold(1);
        chk("disabled_l3_quiet", 64'(pulse_cnt[3]), 64'd0);
        mark = cyc;
        first_pulse[3] = -1;
        k = 0;
        while (first_pulse[3] < 0 && k < 400) begin
            hold(1);
            k++;
        end
        chk_range("restore_first_l3", first_pulse[3] - mark, 129, 144);

        // Line 2 drops from 115200 to 50 baud.
        cur_spd[11:8] = 4'd0;
        hold(1);
        mark = cyc;
        first_pulse[2] = -1;
        k = 0;
        while (first_pulse[2] < 0 && k < 26000) begin
            hold(1);
            k++;
        end
        chk_range("slow_first_l2", first_pulse[2] - mark, 24992, 25016);

        // clr pulse with every line at 115200.
        cur_spd = 32'hFFFF_FFFF;
        hold(32);
        drive_cycle(cur_en, cur_spd, 1'b1, e);
        mark = cyc;
        for (int n = 0; n < 8; n++) first_pulse[n] = -1;
        hold(1);
        chk("clr_next_zero", {56'd0, brgCLKEN}, 64'd0);
        k = 0;
        while (k < 200) begin
            found = 1'b1;
            for (int n = 0; n < 8; n++) if (first_pulse[n] < 0) found = 1'b0;
            if (found) break;
            hold(1);
            k++;
        end
        for (int n = 0; n < 8; n++)
            chk_range($sformatf("clr_first_l%0d", n), first_pulse[n] - mark, 8, 144);
        clear_counts();
        hold(4000);
        for (int n = 0; n < 8; n++)
            chk_rate($sformatf("clr_rate_l%0d", n), pulse_cnt[n], exp_pulses(4000, 15));

        // Random traffic: speed changes, enable toggles and occasional clr.
        cur_spd = $urandom;
        cur_en = 8'($urandom);
        for (int i = 0; i < 3000; i++) begin
            int r;
            int ln;
            logic c;
            r = $urandom_range(0, 255);
            if (r < 4) begin
                ln = $urandom_range(0, 7);
                cur_spd[ln*4 +: 4] = 4'($urandom_range(0, 15));
            end else if (r < 6) begin
                ln = $urandom_range(0, 7);
                cur_en[ln] = ~cur_en[ln];
            end
            c = ($urandom_range(0, 199) == 0);
            drive_cycle(cur_en, cur_spd, c, e);
        end

        // Asynchronous reset landing on an active pulse.
        cur_en = 8'hFF;
        cur_spd = 32'hFFFF_FFFF;
        hold(16);
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            drive_cycle(cur_en, cur_spd, 1'b0, e);
            if (e != 8'h00) found = 1'b1;
        end
        chk("pulse_found", {63'd0, found}, 64'd1);
        @(posedge clk);
        #3;
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("async_rst_clears", {56'd0, brgCLKEN}, 64'd0);
        exp_q.delete();
        model_reset();
        repeat (3) @(posedge clk);

        // Post-reset behaviour matches the single-line 9600 case.
        cur_spd = $urandom;
        cur_spd[3:0] = 4'd14;
        cur_en = 8'h01;
        release_reset(cur_en, cur_spd);
        clear_counts();
        hold(4000);
        chk_rate("post_rst_rate_l0", pulse_cnt[0], exp_pulses(4000, 14));
        others = 0;
        for (int n = 1; n < 8; n++) others += pulse_cnt[n];
        chk("post_rst_quiet", 64'(others), 64'd0);

        @(posedge clk);
        #2;
        mon_en = 1'b0;
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
